// File: rtl/mem_port_arbiter.sv
// Purpose : two-requester round-robin arbiter/sequencer for the single-port
//           256x8 SPI register memory, with a write-protected upper region.
// Latency : gnt one edge after req is sampled; rvalid one edge after gnt.
// Backpressure: a requester holds req and its fields until gnt; one access
//           every two cycles, with an idle bubble after each access.
//
// Ports:
//   clk, rstN                 system clock, async active-low reset
//   reqX/weX/addrX/wdataX     requester X access request and fields (X = 0, 1)
//   gntX                      one-cycle pulse while requester X is served
//   rvalidX/rdataX            read-data pulse and captured read data
//   errX                      write to the protected region rejected (with gnt)
//   memAddr/memWdata/memWe    registered memory port drive
//   memRdata                  memory read data, combinational from memAddr
module mem_port_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hF0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic                owner_q,     owner_d;
  logic                last_q,      last_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q,    mem_we_d;
  logic                acc_we_q,    acc_we_d;    // requested direction of the access in flight
  logic                rej_q,       rej_d;       // access in flight is a rejected write
  logic [DATA_W-1:0]   rdata0_q,    rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,    rdata1_d;
  logic                rvalid0_q,   rvalid0_d;
  logic                rvalid1_q,   rvalid1_d;

  // Winner selection and the winner's fields, only meaningful in IDLE.
  logic                win_sel;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_rej;

  always_comb begin
    // On a tie the requester that was not served last wins.
    win_sel   = (req0 && req1) ? ~last_q : req1;
    win_we    = win_sel ? we1    : we0;
    win_addr  = win_sel ? addr1  : addr0;
    win_wdata = win_sel ? wdata1 : wdata0;
    // Only the local side is barred from writing the protected region.
    win_rej   = win_sel && win_we && (win_addr >= PROT_BASE);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    acc_we_d    = acc_we_q;
    rej_d       = rej_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d     = ST_ACC;
          owner_d     = win_sel;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          mem_we_d    = win_we && !win_rej;
          acc_we_d    = win_we;
          rej_d       = win_rej;
        end
      end
      ST_ACC: begin
        // Memory read data is valid for the whole ACC cycle; capture it on exit.
        if (!acc_we_q) begin
          if (owner_q) begin
            rdata1_d  = memRdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = memRdata;
            rvalid0_d = 1'b1;
          end
        end
        last_d   = owner_q;
        mem_we_d = 1'b0;
        rej_d    = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;   // requester 0 wins the first tie
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      acc_we_q    <= 1'b0;
      rej_q       <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      acc_we_q    <= acc_we_d;
      rej_q       <= rej_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign gnt0     = (state_q == ST_ACC) && !owner_q;
  assign gnt1     = (state_q == ST_ACC) &&  owner_q;
  assign err0     = gnt0 && rej_q;
  assign err1     = gnt1 && rej_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memWe    = mem_we_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstN) !(gnt0 && gnt1));
  a_gnt_bubble: assert property (@(posedge clk) disable iff (!rstN) (gnt0 || gnt1) |=> !(gnt0 || gnt1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1, memWe;
  logic [7:0] rdata0, rdata1, memAddr, memWdata, memRdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rstN(rstN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memRdata(memRdata)
  );

  // External memory: unwritten locations read as addr ^ 8'h3C.
  logic [7:0] tb_mem [256];
  logic       tb_wr  [256];
  always @(posedge clk) begin
    if (memWe) begin
      tb_mem[memAddr] <= memWdata;
      tb_wr[memAddr]  <= 1'b1;
    end
  end
  assign memRdata = (tb_wr[memAddr] === 1'b1) ? tb_mem[memAddr] : (memAddr ^ 8'h3C);

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester agents.
  logic       a_act [2];
  logic       a_rep [2];
  logic       a_we  [2];
  logic [7:0] a_addr[2];
  logic [7:0] a_wd  [2];

  task automatic drive();
    req0 = a_act[0]; we0 = a_we[0]; addr0 = a_addr[0]; wdata0 = a_wd[0];
    req1 = a_act[1]; we1 = a_we[1]; addr1 = a_addr[1]; wdata1 = a_wd[1];
  endtask

  task automatic post(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
    a_act[r] = 1'b1; a_we[r] = we; a_addr[r] = a; a_wd[r] = d;
    drive();
  endtask

  task automatic agents_clear();
    for (int r = 0; r < 2; r++) begin
      a_act[r] = 1'b0; a_rep[r] = 1'b0; a_we[r] = 1'b0; a_addr[r] = '0; a_wd[r] = '0;
    end
    drive();
  endtask

  // Transaction-level reference: an access takes the grant cycle, then a
  // mandatory idle cycle in which its read result appears.
  logic       m_busy;
  int         m_owner, m_last;
  logic       m_we, m_ok;
  logic [7:0] m_a, m_d;
  logic [7:0] m_mem [256];
  logic       e_gnt[2], e_rv[2], e_err[2], e_mwe;
  logic [7:0] e_rdata[2], e_maddr, e_mwd;

  task automatic m_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 1;
    for (int r = 0; r < 2; r++) begin
      e_gnt[r] = 1'b0; e_rv[r] = 1'b0; e_err[r] = 1'b0; e_rdata[r] = '0;
    end
    e_mwe = 1'b0; e_maddr = '0; e_mwd = '0;
  endtask

  task automatic m_step();
    int w;
    for (int r = 0; r < 2; r++) begin
      e_gnt[r] = 1'b0; e_rv[r] = 1'b0; e_err[r] = 1'b0;
    end
    e_mwe = 1'b0;
    if (m_busy) begin
      if (!m_we) begin
        e_rdata[m_owner] = m_mem[m_a];
        e_rv[m_owner]    = 1'b1;
      end else if (m_ok) begin
        m_mem[m_a] = m_d;
      end
      m_last = m_owner;
      m_busy = 1'b0;
    end else if (req0 || req1) begin
      w       = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
      m_owner = w;
      m_busy  = 1'b1;
      m_we    = a_we[w];
      m_a     = a_addr[w];
      m_d     = a_wd[w];
      m_ok    = !(w == 1 && m_a >= 8'hF0);
      e_gnt[w] = 1'b1;
      e_err[w] = m_we && !m_ok;
      e_mwe    = m_we && m_ok;
      e_maddr  = m_a;
      e_mwd    = m_d;
    end
  endtask

  task automatic step();
    m_step();
    @(posedge clk); #1;
    chk("gnt0",    32'(gnt0),    32'(e_gnt[0]));
    chk("gnt1",    32'(gnt1),    32'(e_gnt[1]));
    chk("err0",    32'(err0),    32'(e_err[0]));
    chk("err1",    32'(err1),    32'(e_err[1]));
    chk("rvalid0", 32'(rvalid0), 32'(e_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(e_rv[1]));
    chk("rdata0",  32'(rdata0),  32'(e_rdata[0]));
    chk("rdata1",  32'(rdata1),  32'(e_rdata[1]));
    chk("memWe",   32'(memWe),   32'(e_mwe));
    chk("memAddr", 32'(memAddr), 32'(e_maddr));
    chk("memWdata",32'(memWdata),32'(e_mwd));
    if (gnt0 && !a_rep[0]) a_act[0] = 1'b0;
    if (gnt1 && !a_rep[1]) a_act[1] = 1'b0;
    drive();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'({gnt0, gnt1}),       0);
    chk({tag, "_rv"},    32'({rvalid0, rvalid1}), 0);
    chk({tag, "_err"},   32'({err0, err1}),       0);
    chk({tag, "_we"},    32'(memWe),              0);
    chk({tag, "_addr"},  32'(memAddr),            0);
    chk({tag, "_wd"},    32'(memWdata),           0);
    chk({tag, "_rd0"},   32'(rdata0),             0);
    chk({tag, "_rd1"},   32'(rdata1),             0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    m_reset();
    agents_clear();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int         seq_exp[8];
  int         seq_got;
  logic [7:0] ra;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
    seq_exp[0] = 1; seq_exp[1] = 0; seq_exp[2] = 2; seq_exp[3] = 0;
    seq_exp[4] = 1; seq_exp[5] = 0; seq_exp[6] = 2; seq_exp[7] = 0;

    // Reset and single write from requester 0.
    do_reset();
    chk_reset_outputs("rst");
    rstN = 1'b1;
    post(0, 1'b1, 8'h10, 8'hA5);
    step();
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_we",   32'(memWe), 1);
    chk("t1_addr", 32'(memAddr), 32'h10);
    chk("t1_wd",   32'(memWdata), 32'hA5);
    chk("t1_err0", 32'(err0), 0);
    step();
    chk("t1_we_off", 32'(memWe), 0);

    // Requester 1 reads it back.
    post(1, 1'b0, 8'h10, 8'h00);
    step();
    chk("t2_gnt1", 32'(gnt1), 1);
    step();
    chk("t2_rv1",  32'(rvalid1), 1);
    chk("t2_rd1",  32'(rdata1), 32'hA5);
    chk("t2_rd0",  32'(rdata0), 0);

    // Both held from the first edge after reset: strict alternation.
    do_reset();
    post(0, 1'b0, 8'h10, 8'h00);
    post(1, 1'b0, 8'h40, 8'h00);
    a_rep[0] = 1'b1; a_rep[1] = 1'b1;
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      seq_got = 32'({gnt1, gnt0});
      chk("t3_order", seq_got, seq_exp[i]);
    end
    agents_clear();
    step();

    // Protected region: rejected for requester 1, accepted for requester 0.
    post(1, 1'b1, 8'hF3, 8'h55);
    step();
    chk("t4_gnt1", 32'(gnt1), 1);
    chk("t4_err1", 32'(err1), 1);
    chk("t4_we",   32'(memWe), 0);
    step();
    post(1, 1'b0, 8'hF3, 8'h00);
    step();
    chk("t4_rd_err", 32'(err1), 0);
    step();
    chk("t4_old", 32'(rdata1), 32'hCF);
    post(0, 1'b1, 8'hF3, 8'h55);
    step();
    chk("t4_we0",  32'(memWe), 1);
    chk("t4_err0", 32'(err0), 0);
    step();
    post(0, 1'b0, 8'hF3, 8'h00);
    step();
    step();
    chk("t4_new", 32'(rdata0), 32'h55);

    // Reset pulse in the middle of a requester 0 write.
    post(0, 1'b1, 8'h20, 8'h77);
    step();
    chk("t5_acc_we", 32'(memWe), 1);
    #2 rstN = 1'b0;
    #1;
    chk_reset_outputs("t5");
    m_reset();
    agents_clear();
    @(posedge clk); #1;
    chk("t5_norv", 32'({rvalid0, rvalid1}), 0);
    rstN = 1'b1;
    post(0, 1'b0, 8'h20, 8'h00);
    post(1, 1'b0, 8'h21, 8'h00);
    step();
    chk("t5_tie0", 32'(gnt0), 1);
    step();
    chk("t5_unwritten", 32'(rdata0), 32'h1C);
    step();
    chk("t5_gnt1", 32'(gnt1), 1);
    step();
    chk("t5_rd1", 32'(rdata1), 32'h1D);

    // Request raised and dropped between sampling edges.
    #1 req0 = 1'b1;
    #2 req0 = 1'b0;
    step();
    chk("t6_gnt0", 32'(gnt0), 0);
    chk("t6_we",   32'(memWe), 0);

    // Random traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!a_act[r] && $urandom_range(0, 2) == 0) begin
          ra = 8'($urandom);
          if ($urandom_range(0, 3) == 0) ra = ra | 8'hF0;
          post(r, 1'($urandom), ra, 8'($urandom));
        end else if (a_act[r] && $urandom_range(0, 15) == 0) begin
          a_act[r] = 1'b0;
          drive();
        end
      end
      step();
    end
    agents_clear();
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
